mc_main_control: RTL and testbench



---
 rtl/mc_main_control.sv | 189 ++++++++++++++++++
 tb/tb_mc_main_control.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mc_main_control.sv
// Multi-cycle main control FSM for the RV32I core: sequences each instruction and drives datapath selects/strobes.
// Optional build macro MC_BNE_EN: when defined, BRANCH with funct3=001 is decoded as BNE.
//
// state    | meaning
// FETCH    | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE   | read registers, compute branch/JAL target
// MEMADR   | compute load/store address
// MEMREAD  | load data access, wait for memory
// MEMWB    | write loaded data to rd
// MEMWRITE | store data access, wait for memory
// EXECR    | register-register ALU operation
// EXECI    | register-immediate ALU operation
// ALUWB    | write ALU result to rd
// JAL      | PC <= target, ALU forms old PC+4 for rd
// BRANCH   | compare, load PC when taken
// TRAP     | undefined opcode, held until reset
module mc_main_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BRANCH   = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t state_q, state_d;
  logic   br_ok, br_taken;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  assign state = state_q;

  // Unsupported branch senses fall through with no PC load and a one-cycle illegal flag.
  always_comb begin
    br_ok    = 1'b0;
    br_taken = 1'b0;
    case (funct3)
      3'b000: begin br_ok = 1'b1; br_taken = zero; end
`ifdef MC_BNE_EN
      3'b001: begin br_ok = 1'b1; br_taken = !zero; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_JAL:            state_d = S_JAL;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = S_ALUWB;
      end
      S_BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        instr_done = 1'b1;
        pc_write   = br_ok & br_taken;
        illegal    = !br_ok;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset masks every strobe and presents the FETCH selects.
    if (reset) begin
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      adr_src    = 1'b0;
      result_src = 2'b10;
      alu_src_a  = 2'b00;
      alu_src_b  = 2'b10;
      alu_op     = 2'b00;
    end
  end

endmodule

// File: tb/tb_mc_main_control.sv
// Self-checking bench for mc_main_control: directed vector table, hand sequences and random instruction streams.
module tb_mc_main_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       pc_write, ir_write, adr_src, mem_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;
  logic       instr_done, illegal;
  logic [3:0] state;

  always #5 clk = ~clk;

  mc_main_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .adr_src(adr_src),
    .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

`ifdef MC_BNE_EN
  localparam bit BNE = 1'b1;
`else
  localparam bit BNE = 1'b0;
`endif

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BR  = 7'b1100011;

  typedef struct {
    string       nm;
    logic        rst;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        z;
    logic        mr;
    logic [18:0] e;
  } vec_t;

  vec_t tbl[$];
  vec_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Expected output word: {pcw,irw,adr,mw,rw,result_src,a,b,alu_op,done,illegal,state}
  function automatic logic [18:0] mk(input logic [3:0] st, input logic pcw, irw, adr, mw, rw,
                                     input logic [1:0] rs, a, b, op, input logic done, ill);
    return {pcw, irw, adr, mw, rw, rs, a, b, op, done, ill, st};
  endfunction

  function automatic logic [18:0] e_fetch(input logic mr);   return mk(0, mr, mr, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0); endfunction
  function automatic logic [18:0] e_dec();                   return mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0); endfunction
  function automatic logic [18:0] e_madr();                  return mk(2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0); endfunction
  function automatic logic [18:0] e_mrd();                   return mk(3, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0); endfunction
  function automatic logic [18:0] e_mwb();                   return mk(4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 1, 0); endfunction
  function automatic logic [18:0] e_mwr(input logic mr);     return mk(5, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, mr, 0); endfunction
  function automatic logic [18:0] e_exr();                   return mk(6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0); endfunction
  function automatic logic [18:0] e_exi();                   return mk(7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0); endfunction
  function automatic logic [18:0] e_awb();                   return mk(8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 1, 0); endfunction
  function automatic logic [18:0] e_jal();                   return mk(9, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0); endfunction
  function automatic logic [18:0] e_br(input logic pcw, ill); return mk(10, pcw, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 1, ill); endfunction
  function automatic logic [18:0] e_trap();                  return mk(11, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1); endfunction
  function automatic logic [18:0] e_rst(input logic [3:0] st); return mk(st, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0); endfunction

  function automatic vec_t v(input string nm, input logic rst, input logic [6:0] opc, input logic [2:0] f3,
                             input logic z, input logic mr, input logic [18:0] e);
    vec_t r;
    r.nm = nm; r.rst = rst; r.opc = opc; r.f3 = f3; r.z = z; r.mr = mr; r.e = e;
    return r;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic apply(input vec_t r);
    logic [18:0] got;
    reset = r.rst; opcode = r.opc; funct3 = r.f3; zero = r.z; mem_ready = r.mr;
    #2;
    got = {pc_write, ir_write, adr_src, mem_write, reg_write, result_src, alu_src_a, alu_src_b,
           alu_op, instr_done, illegal, state};
    n_cmp++;
    if (got !== r.e) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h expected=%h", r.nm, $time, got, r.e);
    end
    @(posedge clk); #1;
  endtask

  // Instruction-level reference: expands one instruction with its stall counts into per-cycle expectations.
  task automatic expand(input logic [6:0] opc, input logic [2:0] f3, input logic z, input int fs, input int ms);
    bit ok, taken;
    for (int i = 0; i < fs; i++) q.push_back(v("r_fetch_stall", 0, opc, f3, rb(), 0, e_fetch(0)));
    q.push_back(v("r_fetch", 0, opc, f3, rb(), 1, e_fetch(1)));
    q.push_back(v("r_decode", 0, opc, f3, rb(), rb(), e_dec()));
    case (opc)
      LW: begin
        q.push_back(v("r_memadr", 0, opc, f3, rb(), rb(), e_madr()));
        for (int i = 0; i < ms; i++) q.push_back(v("r_memread_stall", 0, opc, f3, rb(), 0, e_mrd()));
        q.push_back(v("r_memread", 0, opc, f3, rb(), 1, e_mrd()));
        q.push_back(v("r_memwb", 0, opc, f3, rb(), rb(), e_mwb()));
      end
      SW: begin
        q.push_back(v("r_memadr", 0, opc, f3, rb(), rb(), e_madr()));
        for (int i = 0; i < ms; i++) q.push_back(v("r_memwrite_stall", 0, opc, f3, rb(), 0, e_mwr(0)));
        q.push_back(v("r_memwrite", 0, opc, f3, rb(), 1, e_mwr(1)));
      end
      RT: begin
        q.push_back(v("r_execr", 0, opc, f3, rb(), rb(), e_exr()));
        q.push_back(v("r_aluwb", 0, opc, f3, rb(), rb(), e_awb()));
      end
      IT: begin
        q.push_back(v("r_execi", 0, opc, f3, rb(), rb(), e_exi()));
        q.push_back(v("r_aluwb", 0, opc, f3, rb(), rb(), e_awb()));
      end
      JL: begin
        q.push_back(v("r_jal", 0, opc, f3, rb(), rb(), e_jal()));
        q.push_back(v("r_aluwb", 0, opc, f3, rb(), rb(), e_awb()));
      end
      BR: begin
        ok    = (f3 == 3'd0) || (BNE && f3 == 3'd1);
        taken = ok && ((f3 == 3'd0) ? z : !z);
        q.push_back(v("r_branch", 0, opc, f3, z, rb(), e_br(taken, !ok)));
      end
      default: begin
        for (int i = 0; i <= ms; i++) q.push_back(v("r_trap", 0, opc, f3, rb(), rb(), e_trap()));
        q.push_back(v("r_trap_reset", 1, opc, f3, rb(), rb(), e_rst(4'd11)));
      end
    endcase
  endtask

  initial begin
    logic [6:0] ops[7];
    logic [6:0] bad[3];
    ops = '{LW, SW, RT, IT, JL, BR, 7'b1111111};
    bad = '{7'b1111111, 7'b0000000, 7'b0110111};

    tbl.push_back(v("reset_state", 1, 7'd0, 3'd0, 0, 0, e_rst(4'd0)));
    tbl.push_back(v("rtype_fetch", 0, RT, 3'd0, 0, 1, e_fetch(1)));
    tbl.push_back(v("rtype_decode", 0, RT, 3'd0, 0, 1, e_dec()));
    tbl.push_back(v("rtype_execr", 0, RT, 3'd0, 0, 1, e_exr()));
    tbl.push_back(v("rtype_aluwb", 0, RT, 3'd0, 0, 1, e_awb()));
    tbl.push_back(v("lw_fetch", 0, LW, 3'd2, 0, 1, e_fetch(1)));
    tbl.push_back(v("lw_decode", 0, LW, 3'd2, 0, 1, e_dec()));
    tbl.push_back(v("lw_memadr", 0, LW, 3'd2, 0, 1, e_madr()));
    tbl.push_back(v("lw_memread_stall1", 0, LW, 3'd2, 0, 0, e_mrd()));
    tbl.push_back(v("lw_memread_stall2", 0, LW, 3'd2, 0, 0, e_mrd()));
    tbl.push_back(v("lw_memread", 0, LW, 3'd2, 0, 1, e_mrd()));
    tbl.push_back(v("lw_memwb", 0, LW, 3'd2, 0, 1, e_mwb()));
    tbl.push_back(v("beq_t_fetch", 0, BR, 3'd0, 1, 1, e_fetch(1)));
    tbl.push_back(v("beq_t_decode", 0, BR, 3'd0, 1, 1, e_dec()));
    tbl.push_back(v("beq_taken", 0, BR, 3'd0, 1, 1, e_br(1, 0)));
    tbl.push_back(v("beq_n_fetch", 0, BR, 3'd0, 0, 1, e_fetch(1)));
    tbl.push_back(v("beq_n_decode", 0, BR, 3'd0, 0, 1, e_dec()));
    tbl.push_back(v("beq_not_taken", 0, BR, 3'd0, 0, 1, e_br(0, 0)));
    tbl.push_back(v("bne_fetch", 0, BR, 3'd1, 0, 1, e_fetch(1)));
    tbl.push_back(v("bne_decode", 0, BR, 3'd1, 0, 1, e_dec()));
    tbl.push_back(v("bne_branch", 0, BR, 3'd1, 0, 1, e_br(BNE, !BNE)));
    tbl.push_back(v("sw_fetch_stall", 0, SW, 3'd2, 0, 0, e_fetch(0)));
    tbl.push_back(v("sw_fetch", 0, SW, 3'd2, 0, 1, e_fetch(1)));
    tbl.push_back(v("sw_decode", 0, SW, 3'd2, 0, 1, e_dec()));
    tbl.push_back(v("sw_memadr", 0, SW, 3'd2, 0, 1, e_madr()));
    tbl.push_back(v("sw_memwrite_stall", 0, SW, 3'd2, 0, 0, e_mwr(0)));
    tbl.push_back(v("sw_memwrite", 0, SW, 3'd2, 0, 1, e_mwr(1)));
    tbl.push_back(v("jal_fetch", 0, JL, 3'd0, 0, 1, e_fetch(1)));
    tbl.push_back(v("jal_decode", 0, JL, 3'd0, 0, 1, e_dec()));
    tbl.push_back(v("jal_jal", 0, JL, 3'd0, 0, 1, e_jal()));
    tbl.push_back(v("jal_aluwb", 0, JL, 3'd0, 0, 1, e_awb()));
    tbl.push_back(v("itype_fetch", 0, IT, 3'd0, 0, 1, e_fetch(1)));
    tbl.push_back(v("itype_decode", 0, IT, 3'd0, 0, 1, e_dec()));
    tbl.push_back(v("itype_execi", 0, IT, 3'd0, 0, 1, e_exi()));
    tbl.push_back(v("itype_aluwb", 0, IT, 3'd0, 0, 1, e_awb()));
    tbl.push_back(v("bge_fetch", 0, BR, 3'd5, 1, 1, e_fetch(1)));
    tbl.push_back(v("bge_decode", 0, BR, 3'd5, 1, 1, e_dec()));
    tbl.push_back(v("bge_undefined", 0, BR, 3'd5, 1, 1, e_br(0, 1)));
    tbl.push_back(v("after_bge_fetch", 0, RT, 3'd0, 0, 1, e_fetch(1)));

    reset = 1'b1; opcode = 7'd0; funct3 = 3'd0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;
    foreach (tbl[i]) apply(tbl[i]);
    // Table leaves the FSM in DECODE of an R-type; finish it.
    q.push_back(v("rtype2_decode", 0, RT, 3'd0, 0, 0, e_dec()));
    q.push_back(v("rtype2_execr", 0, RT, 3'd0, 0, 0, e_exr()));
    q.push_back(v("rtype2_aluwb", 0, RT, 3'd0, 0, 0, e_awb()));

    // Undefined opcode traps and holds for 10 cycles until reset.
    q.push_back(v("trap_fetch", 0, 7'b1111111, 3'd0, 0, 1, e_fetch(1)));
    q.push_back(v("trap_decode", 0, 7'b1111111, 3'd0, 0, 1, e_dec()));
    for (int i = 0; i < 10; i++)
      q.push_back(v("trap_hold", 0, 7'b1111111, 3'($urandom_range(0, 7)), rb(), rb(), e_trap()));
    q.push_back(v("trap_reset", 1, 7'b1111111, 3'd0, 0, 1, e_rst(4'd11)));
    q.push_back(v("trap_exit_fetch", 0, SW, 3'd0, 0, 1, e_fetch(1)));

    // Reset mid-store: no mem_write in the reset cycle, back to FETCH.
    q.push_back(v("rst_sw_decode", 0, SW, 3'd0, 0, 1, e_dec()));
    q.push_back(v("rst_sw_memadr", 0, SW, 3'd0, 0, 1, e_madr()));
    q.push_back(v("rst_in_memwrite", 1, SW, 3'd0, 0, 1, e_rst(4'd5)));
    q.push_back(v("rst_exit_fetch_stall", 0, SW, 3'd0, 0, 0, e_fetch(0)));
    q.push_back(v("rst_in_fetch", 1, SW, 3'd0, 0, 1, e_rst(4'd0)));
    q.push_back(v("rst_exit_fetch", 0, RT, 3'd0, 0, 1, e_fetch(1)));
    q.push_back(v("rst_rt_decode", 0, RT, 3'd0, 0, 1, e_dec()));
    q.push_back(v("rst_rt_execr", 0, RT, 3'd0, 0, 1, e_exr()));
    q.push_back(v("rst_rt_aluwb", 0, RT, 3'd0, 0, 1, e_awb()));

    for (int n = 0; n < 300; n++) begin
      int k;
      logic [6:0] opc;
      k   = $urandom_range(0, 6);
      opc = (k == 6) ? bad[$urandom_range(0, 2)] : ops[k];
      expand(opc, 3'($urandom_range(0, 7)), rb(),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
             ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
    end

    while (q.size() > 0) apply(q.pop_front());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
